auto_load_seq: RTL and testbench
================================

AUTO_LOAD_SEQ -- requirements
Module: auto_load_seq

Interface
REQ-001 Parameter NWORDS, default 16: number of 16-bit parameter words to load, range 1..64.
REQ-002 Parameter BASE_ADDR, default 12'h000: source address of word 0.
REQ-003 Parameter RD_TMO, default 255: maximum cycles to wait for RD_VLD per word, range 1..255.
REQ-004 CLK  input  1  the only clock; all logic on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 AL_START  input  1  load request from the power-on-reset sequencer; held high for the whole load.
REQ-007 AL_DONE  output  1  1 = idle or load finished; 0 = load in progress.
REQ-008 AL_ERR  output  1  sticky error for the last load (timeout, abort or checksum).
REQ-009 RD_EN  output  1  one-cycle read strobe to the parameter store.
REQ-010 RD_ADDR  output  12  read address, valid while RD_EN=1.
REQ-011 RD_DATA  input  16  read data, valid when RD_VLD=1.
REQ-012 RD_VLD  input  1  read-data valid; latency of at least 1 cycle after RD_EN.
REQ-013 REG_WE  output  1  one-cycle write strobe to the destination register bank.
REQ-014 REG_ADDR  output  6  destination index, equal to the word index.
REQ-015 REG_DATA  output  16  destination data.
REQ-016 AL_STATE  output  3  current state encoding, for debug.

Function
REQ-017 All outputs SHALL be registered, with states IDLE, REQ, WAIT, WRITE, CHK and DONE.
REQ-018 A rising edge of AL_START (current 1, previous registered 0) in IDLE or DONE SHALL move the FSM to REQ, clear AL_ERR and word index, and drive AL_DONE=0 on the next cycle.
REQ-019 REQ SHALL assert RD_EN=1 for exactly one cycle with RD_ADDR=BASE_ADDR+index, then go to WAIT with the timer cleared.
REQ-020 WAIT SHALL ignore RD_VLD in the RD_EN cycle; on RD_VLD=1 it SHALL capture RD_DATA and go to WRITE.
REQ-021 WRITE SHALL assert REG_WE=1 for one cycle with REG_ADDR=index and REG_DATA=captured word, then increment the index.
REQ-022 After WRITE, index<NWORDS SHALL go to REQ; otherwise the FSM SHALL go to CHK if the checksum is enabled, else to DONE.
REQ-023 WAIT reaching RD_TMO cycles without RD_VLD SHALL set AL_ERR=1 and go to DONE, with no write for that word.
REQ-024 In DONE, AL_DONE SHALL be 1 and held until the next AL_START rising edge.
REQ-025 AL_START falling while in REQ/WAIT/WRITE/CHK SHALL abort: no further RD_EN/REG_WE, AL_ERR=1, FSM to DONE on the next cycle.
REQ-026 RD_VLD outside WAIT SHALL be ignored.
REQ-027 A rising edge while busy cannot occur; AL_START level high while busy SHALL NOT restart the load.
REQ-028 Index and timer SHALL NOT wrap: index width 7 bits, timer width 8 bits and saturates.
REQ-029 Best-case latency from the AL_START edge to AL_DONE=1 SHALL be NWORDS*(3+L)+1 cycles, where L is the RD_VLD latency.

Reset
REQ-030 RST SHALL force IDLE and set AL_DONE=1, AL_ERR=0, RD_EN=0, REG_WE=0, RD_ADDR=0, REG_ADDR=0, REG_DATA=0, index=0, timer=0, and prev-AL_START=0.
REQ-031 RST asserted mid-load SHALL take effect on the next edge, with no pending strobe issued afterwards.

Configuration
REQ-032 With macro AL_CHKSUM_EN defined, CHK SHALL read one extra word at BASE_ADDR+NWORDS, compare it to the mod-2^16 sum of all loaded words, set AL_ERR=1 on mismatch, then go to DONE; the extra read obeys the timeout.
REQ-033 Without AL_CHKSUM_EN, the CHK state, accumulator and extra read SHALL be absent.

Structure
REQ-034 Package al_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-035 The per-word timeout counter SHALL be sub-module al_rd_timer, with clear, enable and expired outputs.

Verification
REQ-036 NWORDS=4, RD_VLD latency 2, data 1,2,3,4 -> four REG_WE pulses at addresses 0..3, AL_DONE 0->1 after 21 cycles, AL_ERR=0.
REQ-037 RD_VLD never returned for word 2 -> two writes, AL_ERR=1, AL_DONE=1 exactly RD_TMO cycles after the third RD_EN.
REQ-038 AL_START dropped during WAIT of word 1 -> no further strobes, AL_ERR=1, AL_DONE=1 next cycle; re-raise AL_START -> clean reload, AL_ERR=0.
REQ-039 RST asserted during WRITE -> all outputs at reset values next cycle, REG_WE=0.
REQ-040 AL_CHKSUM_EN, data 0xFFFF,0x0002 with stored sum 0x0001 -> AL_ERR=0; stored 0x0002 -> AL_ERR=1.

Source files
------------

// File: rtl/al_pkg.sv
// rtl/al_pkg.sv - state encoding and default parameters for auto_load_seq (ST_CHK only with AL_CHKSUM_EN)
package al_pkg;

    localparam int          NWORDS_DEF    = 16;
    localparam logic [11:0] BASE_ADDR_DEF = 12'h000;
    localparam int          RD_TMO_DEF    = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef AL_CHKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_DONE  = 3'd5
    } al_state_t;

endpackage

// File: rtl/al_rd_timer.sv
// rtl/al_rd_timer.sv - per-word read timeout counter, saturating at 255
module al_rd_timer
    import al_pkg::*;
#(
    parameter int RD_TMO = RD_TMO_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] TMO_LAST = 8'(RD_TMO - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // cnt lags the wait-cycle count by one, so this fires on the RD_TMO-th wait cycle
    assign expired = (cnt >= TMO_LAST);

endmodule

// File: rtl/auto_load_seq.sv
// rtl/auto_load_seq.sv - power-on parameter auto-load sequencer (optional checksum word: AL_CHKSUM_EN)
module auto_load_seq
    import al_pkg::*;
#(
    parameter int          NWORDS    = NWORDS_DEF,
    parameter logic [11:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          RD_TMO    = RD_TMO_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AL_START,
    output logic        AL_DONE,
    output logic        AL_ERR,
    output logic        RD_EN,
    output logic [11:0] RD_ADDR,
    input  logic [15:0] RD_DATA,
    input  logic        RD_VLD,
    output logic        REG_WE,
    output logic [5:0]  REG_ADDR,
    output logic [15:0] REG_DATA,
    output logic [2:0]  AL_STATE
);

    localparam logic [6:0] LAST_IDX = 7'(NWORDS);

    al_state_t   state;
    logic [6:0]  idx;
    logic [15:0] word_q;
    logic        prev_start;
    logic        start_rise;
    logic        busy;
    logic        vld_ok;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_exp;
`ifdef AL_CHKSUM_EN
    logic [15:0] sum_q;
    logic        chk_issued;
`endif

    assign start_rise = AL_START && !prev_start;
    // data can never be valid in the strobe cycle itself
    assign vld_ok     = RD_VLD && !RD_EN;
    assign AL_STATE   = state;

`ifdef AL_CHKSUM_EN
    assign tmr_clr = (state == ST_REQ) || (state == ST_CHK && !chk_issued);
    assign tmr_en  = (state == ST_WAIT) || (state == ST_CHK && chk_issued);
    assign busy    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_WRITE) || (state == ST_CHK);
`else
    assign tmr_clr = (state == ST_REQ);
    assign tmr_en  = (state == ST_WAIT);
    assign busy    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_WRITE);
`endif

    al_rd_timer #(
        .RD_TMO (RD_TMO)
    ) u_rd_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            AL_DONE    <= 1'b1;
            AL_ERR     <= 1'b0;
            RD_EN      <= 1'b0;
            RD_ADDR    <= '0;
            REG_WE     <= 1'b0;
            REG_ADDR   <= '0;
            REG_DATA   <= '0;
            idx        <= '0;
            word_q     <= '0;
            prev_start <= 1'b0;
`ifdef AL_CHKSUM_EN
            sum_q      <= '0;
            chk_issued <= 1'b0;
`endif
        end else begin
            prev_start <= AL_START;
            RD_EN      <= 1'b0;
            REG_WE     <= 1'b0;
            if (busy && !AL_START) begin
                AL_ERR  <= 1'b1;
                AL_DONE <= 1'b1;
                state   <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        AL_DONE <= 1'b1;
                        if (start_rise) begin
                            AL_DONE <= 1'b0;
                            AL_ERR  <= 1'b0;
                            idx     <= '0;
                            state   <= ST_REQ;
`ifdef AL_CHKSUM_EN
                            sum_q      <= '0;
                            chk_issued <= 1'b0;
`endif
                        end
                    end
                    ST_REQ: begin
                        RD_EN   <= 1'b1;
                        RD_ADDR <= BASE_ADDR + {5'd0, idx};
                        state   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (vld_ok) begin
                            word_q <= RD_DATA;
`ifdef AL_CHKSUM_EN
                            sum_q  <= sum_q + RD_DATA;
`endif
                            state  <= ST_WRITE;
                        end else if (tmr_exp) begin
                            AL_ERR  <= 1'b1;
                            AL_DONE <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                    ST_WRITE: begin
                        REG_WE   <= 1'b1;
                        REG_ADDR <= idx[5:0];
                        REG_DATA <= word_q;
                        idx      <= idx + 7'd1;
                        if (idx + 7'd1 < LAST_IDX) begin
                            state <= ST_REQ;
                        end else begin
`ifdef AL_CHKSUM_EN
                            state <= ST_CHK;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
`ifdef AL_CHKSUM_EN
                    ST_CHK: begin
                        // first cycle issues the checksum read, then waits like ST_WAIT
                        if (!chk_issued) begin
                            RD_EN      <= 1'b1;
                            RD_ADDR    <= BASE_ADDR + 12'(NWORDS);
                            chk_issued <= 1'b1;
                        end else if (vld_ok) begin
                            if (RD_DATA != sum_q) begin
                                AL_ERR <= 1'b1;
                            end
                            state <= ST_DONE;
                        end else if (tmr_exp) begin
                            AL_ERR  <= 1'b1;
                            AL_DONE <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_auto_load_seq.sv
// tb/tb_auto_load_seq.sv - directed bench for auto_load_seq (checksum case built with AL_CHKSUM_EN)
module tb_auto_load_seq;
    import al_pkg::*;

    localparam int          NW   = 4;
    localparam logic [11:0] BASE = 12'h100;
    localparam int          TMO  = 20;
`ifdef AL_CHKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        AL_START = 1'b0;
    logic        AL_DONE, AL_ERR, RD_EN, REG_WE;
    logic        RD_VLD;
    logic [11:0] RD_ADDR;
    logic [15:0] RD_DATA, REG_DATA;
    logic [5:0]  REG_ADDR;
    logic [2:0]  AL_STATE;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:7];
    int          lat = 2;
    logic        drop_en = 1'b0;
    logic [11:0] drop_addr = '0;
    logic        spur = 1'b0;
    logic        pv [0:7];
    logic [11:0] pa [0:7];

    int          we_cnt = 0;
    logic [5:0]  we_addr [0:15];
    logic [15:0] we_data [0:15];

    auto_load_seq #(
        .NWORDS    (NW),
        .BASE_ADDR (BASE),
        .RD_TMO    (TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .AL_START (AL_START),
        .AL_DONE  (AL_DONE),
        .AL_ERR   (AL_ERR),
        .RD_EN    (RD_EN),
        .RD_ADDR  (RD_ADDR),
        .RD_DATA  (RD_DATA),
        .RD_VLD   (RD_VLD),
        .REG_WE   (REG_WE),
        .REG_ADDR (REG_ADDR),
        .REG_DATA (REG_DATA),
        .AL_STATE (AL_STATE)
    );

    always #5 CLK = ~CLK;

    // parameter store: returns mem[addr-BASE] lat cycles after each RD_EN
    initial begin
        RD_VLD  = 1'b0;
        RD_DATA = '0;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1];
                pa[i] = pa[i-1];
            end
            pv[0]   = RD_EN && !(drop_en && RD_ADDR == drop_addr);
            pa[0]   = RD_ADDR;
            RD_VLD  = pv[lat] || spur;
            RD_DATA = pv[lat] ? mem[3'(pa[lat] - BASE)] : 16'hBEEF;
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (REG_WE && we_cnt < 16) begin
                we_addr[we_cnt] = REG_ADDR;
                we_data[we_cnt] = REG_DATA;
                we_cnt++;
            end
        end
    end

    task automatic set_mem(input logic [63:0] dv);
        for (int i = 0; i < 4; i++) mem[i] = dv[16*i +: 16];
        mem[4] = mem[0] + mem[1] + mem[2] + mem[3];
        mem[5] = '0;
        mem[6] = '0;
        mem[7] = '0;
    endtask

    task automatic run_load(input int mark_n, output int done_cyc, output int mark_cyc);
        int nrd;
        AL_START = 1'b0;
        repeat (3) @(negedge CLK);
        we_cnt   = 0;
        nrd      = 0;
        mark_cyc = -1;
        done_cyc = -1;
        AL_START = 1'b1;
        @(negedge CLK);
        for (int c = 1; c <= 400; c++) begin
            @(negedge CLK);
            if (RD_EN) begin
                nrd++;
                if (nrd == mark_n) mark_cyc = c;
            end
            if (AL_DONE) begin
                done_cyc = c;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        AL_START = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++; if (AL_DONE !== 1'b1) begin n_fail++; $display("FAIL reset_done: got %b want 1", AL_DONE); end
        n_tests++; if (AL_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", AL_ERR); end
        n_tests++; if (RD_EN !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", RD_EN); end
        n_tests++; if (REG_WE !== 1'b0) begin n_fail++; $display("FAIL reset_reg_we: got %b want 0", REG_WE); end
        n_tests++; if (RD_ADDR !== 12'h000) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 000", RD_ADDR); end
        n_tests++; if (REG_ADDR !== 6'd0) begin n_fail++; $display("FAIL reset_reg_addr: got %h want 0", REG_ADDR); end
        n_tests++; if (REG_DATA !== 16'h0000) begin n_fail++; $display("FAIL reset_reg_data: got %h want 0000", REG_DATA); end
        n_tests++; if (AL_STATE !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", AL_STATE, ST_IDLE); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_load(input int l, input logic [63:0] dv);
        int done_cyc, mark_cyc, exp_cyc;
        lat = l;
        set_mem(dv);
        exp_cyc = NW * (3 + l) + 1 + CHK_EXTRA * (2 + l);
        run_load(1, done_cyc, mark_cyc);
        n_tests++; if (done_cyc != exp_cyc) begin n_fail++; $display("FAIL load_l%0d_latency: got %0d want %0d", l, done_cyc, exp_cyc); end
        n_tests++; if (mark_cyc != 1) begin n_fail++; $display("FAIL load_l%0d_first_rd: got cycle %0d want 1", l, mark_cyc); end
        n_tests++; if (AL_ERR !== 1'b0) begin n_fail++; $display("FAIL load_l%0d_err: got %b want 0", l, AL_ERR); end
        n_tests++; if (we_cnt != NW) begin n_fail++; $display("FAIL load_l%0d_writes: got %0d want %0d", l, we_cnt, NW); end
        for (int i = 0; i < NW; i++) begin
            n_tests++; if (we_addr[i] !== 6'(i)) begin n_fail++; $display("FAIL load_l%0d_addr%0d: got %0d want %0d", l, i, we_addr[i], i); end
            n_tests++; if (we_data[i] !== dv[16*i +: 16]) begin n_fail++; $display("FAIL load_l%0d_data%0d: got %h want %h", l, i, we_data[i], dv[16*i +: 16]); end
        end
        // AL_START stays high: level alone must not restart the load
        repeat (10) @(negedge CLK);
        #1;
        n_tests++; if (AL_STATE !== ST_DONE || AL_DONE !== 1'b1) begin n_fail++; $display("FAIL load_l%0d_hold: got state %0d done %b want %0d 1", l, AL_STATE, AL_DONE, ST_DONE); end
        n_tests++; if (we_cnt != NW) begin n_fail++; $display("FAIL load_l%0d_no_restart: got %0d writes want %0d", l, we_cnt, NW); end
    endtask

    task automatic test_timeout;
        int done_cyc, mark_cyc;
        lat = 2;
        set_mem(64'h0004_0003_0002_0001);
        drop_en = 1'b1;
        drop_addr = BASE + 12'd2;
        run_load(3, done_cyc, mark_cyc);
        drop_en = 1'b0;
        n_tests++; if (mark_cyc != 11) begin n_fail++; $display("FAIL tmo_third_rd: got cycle %0d want 11", mark_cyc); end
        n_tests++; if (done_cyc - mark_cyc != TMO) begin n_fail++; $display("FAIL tmo_delay: got %0d want %0d", done_cyc - mark_cyc, TMO); end
        n_tests++; if (we_cnt != 2) begin n_fail++; $display("FAIL tmo_writes: got %0d want 2", we_cnt); end
        n_tests++; if (AL_ERR !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", AL_ERR); end
        n_tests++; if (AL_STATE !== ST_DONE) begin n_fail++; $display("FAIL tmo_state: got %0d want %0d", AL_STATE, ST_DONE); end
    endtask

    task automatic test_abort;
        int nrd, nstb, done_cyc, mark_cyc;
        lat = 2;
        set_mem(64'h0004_0003_0002_0001);
        AL_START = 1'b0;
        repeat (3) @(negedge CLK);
        we_cnt = 0;
        nrd = 0;
        AL_START = 1'b1;
        for (int c = 0; c < 100 && nrd < 2; c++) begin
            @(negedge CLK);
            if (RD_EN) nrd++;
        end
        n_tests++; if (AL_STATE !== ST_WAIT) begin n_fail++; $display("FAIL abort_in_wait: got state %0d want %0d", AL_STATE, ST_WAIT); end
        AL_START = 1'b0;
        @(negedge CLK);
        n_tests++; if (AL_DONE !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b want 1", AL_DONE); end
        n_tests++; if (AL_ERR !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b want 1", AL_ERR); end
        n_tests++; if (AL_STATE !== ST_DONE) begin n_fail++; $display("FAIL abort_state: got %0d want %0d", AL_STATE, ST_DONE); end
        nstb = 0;
        repeat (8) begin
            @(negedge CLK);
            if (RD_EN || REG_WE) nstb++;
        end
        #1;
        n_tests++; if (nstb != 0) begin n_fail++; $display("FAIL abort_strobes: got %0d want 0", nstb); end
        n_tests++; if (we_cnt != 1) begin n_fail++; $display("FAIL abort_writes: got %0d want 1", we_cnt); end
        run_load(1, done_cyc, mark_cyc);
        n_tests++; if (done_cyc != NW * 5 + 1 + CHK_EXTRA * 4) begin n_fail++; $display("FAIL reload_latency: got %0d want %0d", done_cyc, NW * 5 + 1 + CHK_EXTRA * 4); end
        n_tests++; if (AL_ERR !== 1'b0) begin n_fail++; $display("FAIL reload_err: got %b want 0", AL_ERR); end
        n_tests++; if (we_cnt != NW) begin n_fail++; $display("FAIL reload_writes: got %0d want %0d", we_cnt, NW); end
    endtask

    task automatic test_rst_write;
        int nwr;
        lat = 2;
        set_mem(64'h0004_0003_0002_0001);
        AL_START = 1'b0;
        repeat (3) @(negedge CLK);
        we_cnt = 0;
        nwr = 0;
        AL_START = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (AL_STATE == ST_WRITE) begin
                nwr++;
                if (nwr == 2) break;
            end
        end
        n_tests++; if (nwr != 2) begin n_fail++; $display("FAIL rstw_reached: got %0d write states want 2", nwr); end
        RST = 1'b1;
        @(negedge CLK);
        n_tests++; if (REG_WE !== 1'b0) begin n_fail++; $display("FAIL rstw_reg_we: got %b want 0", REG_WE); end
        n_tests++; if (AL_STATE !== ST_IDLE) begin n_fail++; $display("FAIL rstw_state: got %0d want %0d", AL_STATE, ST_IDLE); end
        n_tests++; if (AL_DONE !== 1'b1 || AL_ERR !== 1'b0) begin n_fail++; $display("FAIL rstw_flags: got done %b err %b want 1 0", AL_DONE, AL_ERR); end
        n_tests++; if (RD_EN !== 1'b0 || RD_ADDR !== 12'h000) begin n_fail++; $display("FAIL rstw_rd: got en %b addr %h want 0 000", RD_EN, RD_ADDR); end
        n_tests++; if (REG_ADDR !== 6'd0 || REG_DATA !== 16'h0000) begin n_fail++; $display("FAIL rstw_reg: got addr %0d data %h want 0 0000", REG_ADDR, REG_DATA); end
        repeat (3) @(negedge CLK);
        #1;
        n_tests++; if (we_cnt != 1) begin n_fail++; $display("FAIL rstw_writes: got %0d want 1", we_cnt); end
        AL_START = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_spurious_vld;
        we_cnt = 0;
        spur = 1'b1;
        repeat (5) @(negedge CLK);
        spur = 1'b0;
        @(negedge CLK);
        #1;
        n_tests++; if (AL_STATE !== ST_IDLE) begin n_fail++; $display("FAIL spur_state: got %0d want %0d", AL_STATE, ST_IDLE); end
        n_tests++; if (we_cnt != 0) begin n_fail++; $display("FAIL spur_writes: got %0d want 0", we_cnt); end
        n_tests++; if (AL_DONE !== 1'b1) begin n_fail++; $display("FAIL spur_done: got %b want 1", AL_DONE); end
    endtask

`ifdef AL_CHKSUM_EN
    task automatic test_chksum;
        int done_cyc, mark_cyc;
        lat = 2;
        set_mem(64'h0000_0000_0002_FFFF);
        mem[4] = 16'h0001;
        run_load(5, done_cyc, mark_cyc);
        n_tests++; if (AL_ERR !== 1'b0) begin n_fail++; $display("FAIL chk_good_err: got %b want 0", AL_ERR); end
        n_tests++; if (mark_cyc != 21) begin n_fail++; $display("FAIL chk_rd_cycle: got %0d want 21", mark_cyc); end
        mem[4] = 16'h0002;
        run_load(5, done_cyc, mark_cyc);
        n_tests++; if (AL_ERR !== 1'b1) begin n_fail++; $display("FAIL chk_bad_err: got %b want 1", AL_ERR); end
        n_tests++; if (done_cyc != 25) begin n_fail++; $display("FAIL chk_latency: got %0d want 25", done_cyc); end
    endtask
`endif

    initial begin
        test_reset();
        test_load(2, 64'h0004_0003_0002_0001);
        test_load(1, 64'hFFFF_8000_00FF_1234);
        test_timeout();
        test_abort();
        test_rst_write();
        test_spurious_vld();
`ifdef AL_CHKSUM_EN
        test_chksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
